// File: rtl/simplediv.sv
// simplediv: iterative 32-bit divider producing {remainder, quotient}.
// Integer mode follows RISC-V div/rem semantics (signed or unsigned).
// Carry-less mode divides GF(2) polynomials. Latency is fixed regardless of
// operand values: start edge E0, done pulse seen at E0+ITER+2.
module simplediv #(
  parameter int BITS_PER_CYCLE = 1,
  parameter bit DISABLE_CLDIV  = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        sgn,
  input  logic        clmode,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [63:0] rd,
  output logic        busy,
  output logic        done
);

  localparam int ITER = 32 / BITS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t        state_reg;
  logic [4:0]    count_reg;
  logic [31:0]   a_reg;         // dividend bits still to be consumed, MSB first
  logic [31:0]   b_reg;         // divisor (magnitude in signed integer mode)
  logic [31:0]   mask_reg;      // one-hot MSB of divisor for carry-less steps
  logic [32:0]   rem_reg;       // partial remainder, one spare bit for the compare
  logic [31:0]   q_reg;
  logic [31:0]   dividend_reg;  // original rs1, returned as remainder on divide-by-zero
  logic          cl_reg;
  logic          neg_q_reg;
  logic          neg_r_reg;
  logic          zero_reg;

  logic          cl_eff;
  logic          int_sgn;
  logic [31:0]   rs1_mag;
  logic [31:0]   rs2_mag;
  logic [31:0]   msb_mask;

  logic [32:0]   rem_work;
  logic [32:0]   shifted;
  logic          hit;
  logic [BITS_PER_CYCLE-1:0] q_bits;

  logic [31:0]   q_fix;
  logic [31:0]   r_fix;
  logic [63:0]   rd_next;

  // Carry-less mode vanishes entirely when the GF(2) path is disabled.
  assign cl_eff  = clmode & ~DISABLE_CLDIV;
  assign int_sgn = sgn & ~cl_eff;

  // Magnitudes for signed integer division; 0x80000000 maps onto itself,
  // which is the correct unsigned magnitude.
  assign rs1_mag = (int_sgn && rs1[31]) ? (~rs1 + 32'd1) : rs1;
  assign rs2_mag = (int_sgn && rs2[31]) ? (~rs2 + 32'd1) : rs2;

  // Isolate the highest set bit of the divisor (zero divisor gives zero mask).
  always_comb begin
    msb_mask = '0;
    for (int i = 0; i < 32; i++) begin
      if (rs2[i]) begin
        msb_mask    = '0;
        msb_mask[i] = 1'b1;
      end
    end
  end

  // Retire BITS_PER_CYCLE quotient bits per clock as a chain of restoring steps.
  always_comb begin
    rem_work = rem_reg;
    shifted  = '0;
    hit      = 1'b0;
    q_bits   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted = {rem_work[31:0], a_reg[31-i]};
      if (!DISABLE_CLDIV && cl_reg) begin
        hit = |(shifted[31:0] & mask_reg);
        if (hit) shifted = shifted ^ {1'b0, b_reg};
      end else begin
        hit = (shifted >= {1'b0, b_reg});
        if (hit) shifted = shifted - {1'b0, b_reg};
      end
      q_bits[BITS_PER_CYCLE-1-i] = hit;
      rem_work = shifted;
    end
  end

  // Sign correction and divide-by-zero override applied in the fixup cycle.
  always_comb begin
    q_fix   = neg_q_reg ? (~q_reg + 32'd1) : q_reg;
    r_fix   = neg_r_reg ? (~rem_reg[31:0] + 32'd1) : rem_reg[31:0];
    rd_next = zero_reg ? {dividend_reg, 32'hFFFF_FFFF} : {r_fix, q_fix};
  end

  // Control FSM and datapath registers; start restarts from any state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      mask_reg     <= '0;
      rem_reg      <= '0;
      q_reg        <= '0;
      dividend_reg <= '0;
      cl_reg       <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      zero_reg     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd           <= '0;
    end else if (start) begin
      state_reg    <= CALC;
      count_reg    <= '0;
      a_reg        <= rs1_mag;
      b_reg        <= rs2_mag;
      mask_reg     <= msb_mask;
      rem_reg      <= '0;
      q_reg        <= '0;
      dividend_reg <= rs1;
      cl_reg       <= cl_eff;
      neg_q_reg    <= int_sgn & (rs1[31] ^ rs2[31]);
      neg_r_reg    <= int_sgn & rs1[31];
      zero_reg     <= ~cl_eff & (rs2 == 32'd0);
      busy         <= 1'b1;
      done         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        CALC: begin
          rem_reg   <= rem_work;
          q_reg     <= (q_reg << BITS_PER_CYCLE) | 32'(q_bits);
          a_reg     <= a_reg << BITS_PER_CYCLE;
          count_reg <= count_reg + 5'd1;
          if (count_reg == 5'(ITER - 1)) state_reg <= FIXUP;
        end
        FIXUP: begin
          rd        <= rd_next;
          busy      <= 1'b0;
          done      <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
